phase_detector: RTL and testbench

PHASE_DETECTOR -- requirements
Module: phase_detector

---
 rtl/phase_detector.sv | 145 ++++++++++++++
 tb/tb_phase_detector.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_detector.sv
// Phase detector: measures the lead/lag between the rising edges of two
// asynchronous clocks. Both clocks are sampled as data on the system clock.
// Reports a signed pulse width per comparison and tracks lock once enough
// consecutive comparisons fall within tolerance.
module phase_detector #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_WIDTH   = 8,
  parameter int unsigned LOCK_TOL    = 1,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        ref_clk,
  input  logic                        vco_clk,
  output logic                        up,
  output logic                        down,
  output logic signed [ERR_WIDTH-1:0] phase_err,
  output logic                        err_valid,
  output logic                        lock
);

  localparam int unsigned     CNT_W   = ERR_WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam int unsigned     TOL_W   = 8;
  localparam logic [TOL_W-1:0] TOL_MAX = TOL_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] ref_sync;
  logic [SYNC_STAGES-1:0] vco_sync;
  logic                   ref_prev;
  logic                   vco_prev;
  logic [SYNC_STAGES:0]   arm;

  state_t                 state;
  logic [CNT_W-1:0]       width;
  logic [TOL_W-1:0]       tol_cnt;

  logic                   ref_rise_c;
  logic                   vco_rise_c;
  logic                   close_c;
  logic                   in_tol_c;
  logic [CNT_W-1:0]       width_inc_c;
  logic signed [ERR_WIDTH-1:0] width_s_c;

  // Synchronizers, previous-value registers and post-reset edge arming.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ref_sync <= '0;
      vco_sync <= '0;
      ref_prev <= 1'b0;
      vco_prev <= 1'b0;
      arm      <= '0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_clk};
      vco_sync <= {vco_sync[SYNC_STAGES-2:0], vco_clk};
      ref_prev <= ref_sync[SYNC_STAGES-1];
      vco_prev <= vco_sync[SYNC_STAGES-1];
      arm      <= {arm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are only honoured once the chain and previous-value register hold
  // post-release samples, so a level already high at release is not a rise.
  assign ref_rise_c = arm[SYNC_STAGES] & ref_sync[SYNC_STAGES-1] & ~ref_prev;
  assign vco_rise_c = arm[SYNC_STAGES] & vco_sync[SYNC_STAGES-1] & ~vco_prev;

  assign close_c     = ((state == UP) && vco_rise_c) || ((state == DOWN) && ref_rise_c);
  assign in_tol_c    = (32'(width) <= LOCK_TOL);
  assign width_inc_c = (width == CNT_MAX) ? width : width + CNT_W'(1);
  assign width_s_c   = $signed({1'b0, width});

  // Pulse FSM, saturating width counter, error report and lock tracking.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      up        <= 1'b0;
      down      <= 1'b0;
      width     <= '0;
      phase_err <= '0;
      err_valid <= 1'b0;
      tol_cnt   <= '0;
      lock      <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ref_rise_c && !vco_rise_c) begin
            state <= UP;
            up    <= 1'b1;
            width <= CNT_W'(1);
          end else if (vco_rise_c && !ref_rise_c) begin
            state <= DOWN;
            down  <= 1'b1;
            width <= CNT_W'(1);
          end
        end
        UP: begin
          if (vco_rise_c) begin
            state     <= IDLE;
            up        <= 1'b0;
            phase_err <= width_s_c;
            err_valid <= 1'b1;
          end else begin
            width <= width_inc_c;
          end
        end
        DOWN: begin
          if (ref_rise_c) begin
            state     <= IDLE;
            down      <= 1'b0;
            phase_err <= -width_s_c;
            err_valid <= 1'b1;
          end else begin
            width <= width_inc_c;
          end
        end
        default: begin
          state <= IDLE;
          up    <= 1'b0;
          down  <= 1'b0;
        end
      endcase

      if (close_c) begin
        if (in_tol_c) begin
          if (tol_cnt != TOL_MAX) begin
            tol_cnt <= tol_cnt + TOL_W'(1);
          end
          if (tol_cnt >= TOL_MAX - TOL_W'(1)) begin
            lock <= 1'b1;
          end
        end else begin
          tol_cnt <= '0;
          lock    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_detector.sv
// Self-checking bench for phase_detector: directed scenarios plus a random
// run, all compared cycle by cycle against an event-level reference model.
module tb_phase_detector;

  localparam int unsigned S    = 2;
  localparam int unsigned EW   = 8;
  localparam int unsigned TOL  = 1;
  localparam int unsigned LC   = 4;
  localparam int          MAXW = (1 << (EW - 1)) - 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic ref_clk = 1'b0;
  logic vco_clk = 1'b0;
  logic up, down, err_valid, lock;
  logic signed [EW-1:0] phase_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: sampled input history and pulse bookkeeping.
  bit rq[$];
  bit vq[$];
  int cyc = 0;
  int mode = 0;      // 0 idle, 1 ref leading, 2 vco leading
  int start = 0;
  int tol = 0;
  int exp_err = 0;
  bit exp_valid = 1'b0;
  bit exp_lock = 1'b0;

  phase_detector #(
    .SYNC_STAGES(S),
    .ERR_WIDTH  (EW),
    .LOCK_TOL   (TOL),
    .LOCK_COUNT (LC)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ref_clk  (ref_clk),
    .vco_clk  (vco_clk),
    .up       (up),
    .down     (down),
    .phase_err(phase_err),
    .err_valid(err_valid),
    .lock     (lock)
  );

  always #5 clock = ~clock;

  function automatic logic [EW+3:0] obs_vec();
    return {up, down, err_valid, lock, phase_err};
  endfunction

  function automatic logic [EW+3:0] exp_vec();
    return {(mode == 1), (mode == 2), exp_valid, exp_lock, EW'(exp_err)};
  endfunction

  // Advance one clock edge and update the model from the levels seen there.
  task automatic tick();
    bit rr, vr;
    int w;
    @(posedge clock);
    cyc++;
    exp_valid = 1'b0;
    if (!reset_n) begin
      rq.delete();
      vq.delete();
      mode = 0;
      exp_err = 0;
      tol = 0;
      exp_lock = 1'b0;
    end else begin
      rq.push_back(ref_clk);
      vq.push_back(vco_clk);
      if (rq.size() > S + 2) begin
        void'(rq.pop_front());
        void'(vq.pop_front());
      end
      // A rise needs a low and then a high sample, both taken after reset,
      // observed S edges later.
      rr = (rq.size() == S + 2) && rq[1] && !rq[0];
      vr = (vq.size() == S + 2) && vq[1] && !vq[0];
      if (mode == 0) begin
        if (rr && !vr) begin mode = 1; start = cyc; end
        else if (vr && !rr) begin mode = 2; start = cyc; end
      end else if ((mode == 1 && vr) || (mode == 2 && rr)) begin
        w = cyc - start;
        if (w > MAXW) w = MAXW;
        exp_err = (mode == 1) ? w : -w;
        exp_valid = 1'b1;
        mode = 0;
        if (w <= int'(TOL)) begin
          if (tol < int'(LC)) tol++;
          exp_lock = (tol >= int'(LC));
        end else begin
          tol = 0;
          exp_lock = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ref_clk = 1'($urandom);
      vco_clk = 1'($urandom);
      tick();
      n_checks++;
      if (obs_vec() !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=0", cyc, obs_vec());
      end
    end
    ref_clk = 1'b1;
    vco_clk = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec() || up !== 1'b0) begin
        n_fail++;
        $display("FAIL high_at_release cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    ref_clk = 1'b0;
    repeat (S + 3) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_settle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_up_pulse();
    int ups = 0, downs = 0, evs = 0;
    logic signed [EW-1:0] last = '0;
    for (int i = 0; i < S + 10; i++) begin
      if (i == 0) ref_clk = 1'b1;
      if (i == 3) vco_clk = 1'b1;
      if (i == S + 7) begin ref_clk = 1'b0; vco_clk = 1'b0; end
      tick();
      ups += int'(up);
      downs += int'(down);
      evs += int'(err_valid);
      if (err_valid) last = phase_err;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL up_pulse cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    repeat (S + 2) tick();
    n_checks++;
    if (ups !== 3 || downs !== 0 || evs !== 1 || last !== 8'sd3) begin
      n_fail++;
      $display("FAIL up_pulse_summary got ups=%0d downs=%0d evs=%0d err=%0d exp 3/0/1/3",
               ups, downs, evs, last);
    end
  endtask

  task automatic test_down_pulse();
    int ups = 0, downs = 0, evs = 0;
    logic signed [EW-1:0] last = '0;
    for (int i = 0; i < S + 9; i++) begin
      if (i == 0) vco_clk = 1'b1;
      if (i == 2) ref_clk = 1'b1;
      if (i == S + 6) begin ref_clk = 1'b0; vco_clk = 1'b0; end
      tick();
      ups += int'(up);
      downs += int'(down);
      evs += int'(err_valid);
      if (err_valid) last = phase_err;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL down_pulse cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    repeat (S + 2) tick();
    n_checks++;
    if (ups !== 0 || downs !== 2 || evs !== 1 || last !== 8'hFE) begin
      n_fail++;
      $display("FAIL down_pulse_summary got ups=%0d downs=%0d evs=%0d err=%h exp 0/2/1/fe",
               ups, downs, evs, last);
    end
    // Both edges on the same sampling clock produce nothing.
    ups = 0; downs = 0; evs = 0;
    for (int i = 0; i < S + 8; i++) begin
      if (i == 0) begin ref_clk = 1'b1; vco_clk = 1'b1; end
      if (i == S + 4) begin ref_clk = 1'b0; vco_clk = 1'b0; end
      tick();
      ups += int'(up);
      downs += int'(down);
      evs += int'(err_valid);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL simultaneous cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (ups + downs + evs !== 0) begin
      n_fail++;
      $display("FAIL simultaneous_summary got ups=%0d downs=%0d evs=%0d exp 0/0/0", ups, downs, evs);
    end
  endtask

  task automatic test_saturation();
    for (int dir = 0; dir < 2; dir++) begin
      int hi = 0, evs = 0;
      logic signed [EW-1:0] last = '0;
      logic signed [EW-1:0] want;
      want = (dir == 0) ? 8'sd127 : -8'sd127;
      for (int i = 0; i < 200 + S + 8; i++) begin
        if (i == 0) begin if (dir == 0) ref_clk = 1'b1; else vco_clk = 1'b1; end
        if (i == 200) begin if (dir == 0) vco_clk = 1'b1; else ref_clk = 1'b1; end
        if (i == 200 + S + 4) begin ref_clk = 1'b0; vco_clk = 1'b0; end
        tick();
        hi += (dir == 0) ? int'(up) : int'(down);
        evs += int'(err_valid);
        if (err_valid) last = phase_err;
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL saturation dir=%0d cyc=%0d got=%h exp=%h", dir, cyc, obs_vec(), exp_vec());
        end
      end
      n_checks++;
      if (hi !== 200 || evs !== 1 || last !== want) begin
        n_fail++;
        $display("FAIL saturation_summary dir=%0d got high=%0d evs=%0d err=%0d exp 200/1/%0d",
                 dir, hi, evs, last, want);
      end
    end
  endtask

  task automatic test_lock();
    int evs = 0;
    int w;
    reset_n = 1'b0;
    ref_clk = 1'b0;
    vco_clk = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (S + 3) tick();
    for (int p = 0; p < 5; p++) begin
      w = (p < 4) ? 1 : 3;
      for (int i = 0; i < w + 2 * S + 5; i++) begin
        if (i == 0) ref_clk = 1'b1;
        if (i == w) vco_clk = 1'b1;
        if (i == w + S + 2) begin ref_clk = 1'b0; vco_clk = 1'b0; end
        tick();
        if (err_valid) begin
          evs++;
          n_checks++;
          if (phase_err !== EW'(w)) begin
            n_fail++;
            $display("FAIL lock_width pulse=%0d got=%0d exp=%0d", p, phase_err, w);
          end
        end
        n_checks++;
        if (obs_vec() !== exp_vec() || lock !== (evs == 4)) begin
          n_fail++;
          $display("FAIL lock pulse=%0d cyc=%0d got=%h exp=%h lock_exp=%0d",
                   p, cyc, obs_vec(), exp_vec(), (evs == 4));
        end
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int ups = 0, evs = 0;
    logic signed [EW-1:0] last = '0;
    ref_clk = 1'b1;
    repeat (S + 3) tick();
    n_checks++;
    if (up !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pulse_setup got up=%b exp 1", up);
    end
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (up !== 1'b0 || err_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL mid_pulse_abort got=%h exp=%h", obs_vec(), exp_vec());
    end
    reset_n = 1'b1;
    ref_clk = 1'b0;
    for (int i = 0; i < 2 * S + 9; i++) begin
      if (i == S + 3) ref_clk = 1'b1;
      if (i == S + 5) vco_clk = 1'b1;
      tick();
      ups += int'(up);
      evs += int'(err_valid);
      if (err_valid) last = phase_err;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL mid_pulse_restart cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (ups !== 2 || evs !== 1 || last !== 8'sd2) begin
      n_fail++;
      $display("FAIL mid_pulse_summary got ups=%0d evs=%0d err=%0d exp 2/1/2", ups, evs, last);
    end
    ref_clk = 1'b0;
    vco_clk = 1'b0;
    repeat (S + 3) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) ref_clk = ~ref_clk;
      if ($urandom_range(0, 3) == 0) vco_clk = ~vco_clk;
      reset_n = ($urandom_range(0, 199) != 0);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_up_pulse();
    test_down_pulse();
    test_saturation();
    test_lock();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
